plru_tree: RTL

//  Tree pseudo-LRU replacement tracker for an N-way set-associative cache.

---
 rtl/plru_tree_if.sv | 29 ++
 rtl/plru_tree.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/plru_tree_if.sv
// Access/lookup/flush bundle between the cache controller and the PLRU tracker.
interface plru_tree_if #(
  parameter int NUM_SETS = 4,
  parameter int NUM_WAYS = 4
);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int WAY_W = $clog2(NUM_WAYS);

  logic                flush;
  logic                busy;
  logic                upd_en;
  logic [IDX_W-1:0]    upd_index;
  logic [WAY_W-1:0]    upd_way;
  logic                lkp_en;
  logic [IDX_W-1:0]    lkp_index;
  logic [NUM_WAYS-1:0] lkp_valid;
  logic [WAY_W-1:0]    victim_way;
  logic                victim_vld;

  modport master (
    output flush, upd_en, upd_index, upd_way, lkp_en, lkp_index, lkp_valid,
    input  busy, victim_way, victim_vld
  );

  modport slave (
    input  flush, upd_en, upd_index, upd_way, lkp_en, lkp_index, lkp_valid,
    output busy, victim_way, victim_vld
  );
endinterface

// File: rtl/plru_tree.sv
// Tree pseudo-LRU tracker: per-set tree bits, registered victim select with
// invalid-way priority and same-set update forwarding, plus a flush sweep.
module plru_tree #(
  parameter int NUM_SETS = 4,
  parameter int NUM_WAYS = 4
) (
  input  logic        clk,
  input  logic        rst,
  plru_tree_if.slave  bus
);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int WAY_W  = $clog2(NUM_WAYS);
  localparam int TREE_W = NUM_WAYS - 1;
  localparam logic [TREE_W-1:0] TREE_ONE = TREE_W'(1'b1);
  localparam logic [IDX_W-1:0]  LAST_SET = IDX_W'(NUM_SETS - 1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_FLUSH = 1'b1} state_e;

  // Each node on the way's path is set to point into the opposite subtree.
  function automatic logic [TREE_W-1:0] tree_touch(input logic [TREE_W-1:0] bits,
                                                   input logic [WAY_W-1:0]  way);
    logic [TREE_W-1:0] b;
    logic [WAY_W-1:0]  w;
    logic              dir;
    int                node;
    b    = bits;
    w    = way;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      dir = w[WAY_W-1];
      if (dir) b = b & ~(TREE_ONE << node);
      else     b = b | (TREE_ONE << node);
      node = 2 * node + 1 + int'(dir);
      w    = w << 1;
    end
    return b;
  endfunction

  function automatic logic [WAY_W-1:0] pick_victim(input logic [TREE_W-1:0]   bits,
                                                   input logic [NUM_WAYS-1:0] valid);
    logic [TREE_W-1:0]   sh;
    logic [NUM_WAYS-1:0] vs;
    logic [WAY_W-1:0]    way;
    logic [WAY_W-1:0]    cnt;
    logic                found;
    logic                d;
    int                  node;
    way  = {WAY_W{1'b0}};
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      sh   = bits >> node;
      d    = sh[0];
      way  = (way << 1) | WAY_W'(d);
      node = 2 * node + 1 + int'(d);
    end
    vs    = valid;
    cnt   = {WAY_W{1'b0}};
    found = 1'b0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (!found && !vs[0]) begin
        way   = cnt;
        found = 1'b1;
      end
      vs  = vs >> 1;
      cnt = cnt + WAY_W'(1'b1);
    end
    return way;
  endfunction

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [TREE_W-1:0]   tree_q [NUM_SETS];
  logic [WAY_W-1:0]    victim_way_q, victim_way_d;
  logic                victim_vld_q, victim_vld_d;

  logic                upd_fire_s;
  logic [TREE_W-1:0]   upd_bits_s;
  logic [TREE_W-1:0]   lkp_bits_s;
  logic [WAY_W-1:0]    lkp_victim_s;
  logic                wr_en_s;
  logic [IDX_W-1:0]    wr_idx_s;
  logic [TREE_W-1:0]   wr_bits_s;

  // Update path and same-set forwarding into the lookup
  always_comb begin
    upd_fire_s = (state_q == ST_IDLE) && !bus.flush && bus.upd_en;
    upd_bits_s = tree_touch(tree_q[bus.upd_index], bus.upd_way);
    if (upd_fire_s && (bus.upd_index == bus.lkp_index)) begin
      lkp_bits_s = upd_bits_s;
    end else begin
      lkp_bits_s = tree_q[bus.lkp_index];
    end
    lkp_victim_s = pick_victim(lkp_bits_s, bus.lkp_valid);
  end

  // Sweep FSM, tree write port and victim next-state
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    wr_en_s      = 1'b0;
    wr_idx_s     = bus.upd_index;
    wr_bits_s    = upd_bits_s;
    victim_vld_d = 1'b0;
    victim_way_d = victim_way_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.flush) begin
          state_d = ST_FLUSH;
          ptr_d   = {IDX_W{1'b0}};
        end else begin
          wr_en_s = bus.upd_en;
        end
        if (bus.lkp_en) begin
          victim_vld_d = 1'b1;
          victim_way_d = lkp_victim_s;
        end else begin
          victim_vld_d = 1'b0;
        end
      end
      ST_FLUSH: begin
        wr_en_s   = 1'b1;
        wr_idx_s  = ptr_q;
        wr_bits_s = {TREE_W{1'b0}};
        if (bus.flush) begin
          ptr_d = {IDX_W{1'b0}};
        end else if (ptr_q == LAST_SET) begin
          state_d = ST_IDLE;
          ptr_d   = {IDX_W{1'b0}};
        end else begin
          ptr_d = ptr_q + IDX_W'(1'b1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = {IDX_W{1'b0}};
      end
    endcase
  end

  // State, pointer and registered victim outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= {IDX_W{1'b0}};
      victim_way_q <= {WAY_W{1'b0}};
      victim_vld_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      victim_way_q <= victim_way_d;
      victim_vld_q <= victim_vld_d;
    end
  end

  // Per-set tree bit storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        tree_q[s] <= {TREE_W{1'b0}};
      end
    end else if (wr_en_s) begin
      tree_q[wr_idx_s] <= wr_bits_s;
    end
  end

  assign bus.busy       = (state_q == ST_FLUSH);
  assign bus.victim_way = victim_way_q;
  assign bus.victim_vld = victim_vld_q;
endmodule
